// File: rtl/wbi_arb_pkg.sv
// wbi_arb_pkg: shared types and limits for the Wishbone response arbiters
package wbi_arb_pkg;
  typedef enum logic {IDLE, LOCK} arb_state_t;
  localparam int NREQ_MAX = 8;
endpackage

// File: rtl/wbi_rr_pick.sv
// wbi_rr_pick: round-robin picker, first requester scanning upward from last+1
module wbi_rr_pick import wbi_arb_pkg::*; #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] win,
  output logic         any
);
  logic [W-1:0] idx;
  // scan downward so the nearest requester after last overwrites the rest
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      idx = W'((int'(last) + i) % N);
      win = req[idx] ? idx : win;
    end
  end
  assign any = |req;
endmodule

// File: rtl/wbi_res_arb.sv
// wbi_res_arb: burst-aware round-robin arbiter for the shared response path
module wbi_res_arb import wbi_arb_pkg::*; #(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int BL   = 10,
  parameter int TOW  = 8
) (
  input  logic                     mclk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          src_rval_i,
  output logic [NREQ-1:0]          src_rrdy_o,
  input  logic [NREQ*DW-1:0]       src_dat_i,
  input  logic [NREQ-1:0]          src_ack_i,
  input  logic [NREQ-1:0]          src_lack_i,
  input  logic [NREQ-1:0]          src_err_i,
  input  logic [NREQ*4-1:0]        src_tid_i,
  input  logic                     res_rrdy_i,
  output logic                     res_rval_o,
  output logic [DW-1:0]            res_dat_o,
  output logic                     res_ack_o,
  output logic                     res_lack_o,
  output logic                     res_err_o,
  output logic [3:0]               res_tid_o,
  output logic [$clog2(NREQ)-1:0]  gnt_o,
  output logic                     busy_o,
  output logic [BL-1:0]            beat_cnt_o,
  output logic                     timeout_o
);
  localparam int GW = $clog2(NREQ);
  localparam logic [TOW-1:0] TO_LAST = {{(TOW-1){1'b1}}, 1'b0};
  arb_state_t state_q;
  logic [GW-1:0] gnt_q, last_q, win;
  logic [BL-1:0] beat_cnt_q;
  logic [TOW-1:0] to_cnt_q;
  logic timeout_q, any, lock, gv, xfer, fin, tmo;
  wbi_rr_pick #(.N(NREQ), .W(GW)) u_pick (
    .req(src_rval_i),
    .last(last_q),
    .win(win),
    .any(any)
  );
  assign lock = state_q == LOCK;
  assign gv = src_rval_i[gnt_q];
  assign res_rval_o = lock & gv;
  assign res_dat_o = lock ? src_dat_i[int'(gnt_q)*DW +: DW] : '0;
  assign res_ack_o = lock & src_ack_i[gnt_q];
  assign res_lack_o = lock & src_lack_i[gnt_q];
  assign res_err_o = lock & src_err_i[gnt_q];
  assign res_tid_o = lock ? src_tid_i[int'(gnt_q)*4 +: 4] : '0;
  assign src_rrdy_o = lock ? NREQ'(res_rrdy_i) << gnt_q : '0;
  assign xfer = res_rval_o & res_rrdy_i;
  assign fin = xfer & (res_lack_o | res_err_o);
  // a stalled grantee is dropped on its last tolerated idle cycle
  assign tmo = lock & ~gv & (to_cnt_q == TO_LAST);
  assign gnt_o = gnt_q;
  assign busy_o = lock;
  assign beat_cnt_o = beat_cnt_q;
  assign timeout_o = timeout_q;
  // grant FSM: pick in IDLE, hold the grant until last beat, error or lock timeout
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      last_q <= GW'(NREQ - 1);
      beat_cnt_q <= '0;
      to_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (!lock) begin
        if (any) begin
          state_q <= LOCK;
          gnt_q <= win;
          beat_cnt_q <= '0;
          to_cnt_q <= '0;
        end
      end else begin
        if (xfer) beat_cnt_q <= (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + BL'(1);
        to_cnt_q <= gv ? '0 : to_cnt_q + TOW'(1);
        if (fin || tmo) begin
          state_q <= IDLE;
          last_q <= gnt_q;
          to_cnt_q <= '0;
        end
        timeout_q <= tmo & ~fin;
      end
    end
  end
endmodule

// File: doc/wbi_res_arb.md
# wbi_res_arb

Burst-aware round-robin arbiter for the shared Wishbone-interconnect response path. Up to NREQ response sources each present a valid/ready response stream: the local slave node, the daisy-chain stagging stage, or further ports. The block grants the single upstream response port to one source and holds that grant until the burst's last beat (or an error) is accepted. It replaces the two-input, beat-level arbiter in the slave port, so a burst's beats are never interleaved with another source. A lock timeout releases a grantee that stalls mid-burst.

## Interface
- NREQ, 2, number of response sources (2..8)
- DW, 32, response data width
- BL, 10, burst-beat counter width
- TOW, 8, lock-timeout counter width; timeout after 2^TOW-1 idle cycles
- mclk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- src_rval_i  in  NREQ  per-source response valid
- src_rrdy_o  out  NREQ  per-source ready; only the grantee's bit can be 1
- src_dat_i  in  NREQ*DW  packed data; source k occupies [k*DW +: DW]
- src_ack_i, src_lack_i, src_err_i  in  NREQ each  per-source ack / last-ack / error
- src_tid_i  in  NREQ*4  packed transaction id
- res_rrdy_i  in  1  upstream ready
- res_rval_o  out  1  upstream valid
- res_dat_o  out  DW  muxed data
- res_ack_o, res_lack_o, res_err_o  out  1 each  muxed status
- res_tid_o  out  4  muxed tid
- gnt_o  out  $clog2(NREQ)  current grant index
- busy_o  out  1  1 while in LOCK
- beat_cnt_o  out  BL  beats transferred in the current/last burst
- timeout_o  out  1  one-cycle pulse on lock-timeout release

## Operation
- States: IDLE, LOCK.
- IDLE:
  - all src_rrdy_o=0; res_rval_o=0; res data/status/tid outputs forced to 0.
  - If any src_rval_i is set, the round-robin winner is the first set bit scanning upward from last_q+1, mod NREQ. gnt_q<=winner, beat_cnt_q<=0, to_cnt_q<=0, state->LOCK.
- LOCK:
  - res_*_o = source gnt_q fields; src_rrdy_o[gnt_q]=res_rrdy_i.
  - A transfer is res_rval_o && res_rrdy_i; each transfer does beat_cnt_q+=1, saturating at all-ones.
  - Release on a transfer with lack=1 or err=1: last_q<=gnt_q, state->IDLE.
  - When src_rval_i[gnt_q]=0, to_cnt_q+=1. Any cycle with grantee valid clears to_cnt_q.
  - When to_cnt_q reaches 2^TOW-1: release (last_q<=gnt_q, ->IDLE) and pulse timeout_o.
  - Non-granted sources are never acknowledged. Their rval may stay high indefinitely.
- Reset values: state IDLE, gnt_q=0, last_q=NREQ-1 (source 0 has first priority), beat_cnt_q=0, to_cnt_q=0, timeout_o=0. All outputs are 0.
- Reset asserted mid-burst: immediate return to reset values; the partial burst is abandoned.
- ack=0 beats (write posted/no-data) still count as transfers; only lack/err end the burst.

## Timing
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N makes res_rval_o valid after edge N+1.
- One bubble cycle (IDLE) follows every release. A continuous single-beat stream from one source therefore sustains 1 beat per 2 cycles.
- Ready/valid paths in LOCK are combinational (res_rrdy_i->src_rrdy_o, src->res). No registers on the data path.
- gnt_o, busy_o and beat_cnt_o are registered state outputs.
- timeout_o is registered and high for exactly the cycle after the release edge.
- A lack and a timeout in the same cycle resolve as a normal release, with no timeout_o.

## Structure
- Package wbi_arb_pkg: state typedef (IDLE, LOCK) and the NREQ limit constant.
- Sub-module wbi_rr_pick: combinational round-robin picker (req vector, last index -> winner index, any). It is reusable by the command-side arbiters.
- Top: FSM, counters and output mux.

## Test plan
- Reset, with src_rval_i=2'b11 held throughout -> all outputs 0. First grant is 0 at the cycle after release of reset; last_q=1.
- Source 0 sends a 4-beat burst (lack on beat 4) while source 1 is valid throughout -> four beats all show tid of source 0 with src_rrdy_o[1]=0. Then one IDLE cycle, then gnt_o=1.
- Both sources send single beats (lack=1) continuously -> grants alternate 0,1,0,1, with beat_cnt_o=1 each time.
- res_rrdy_i=0 for 5 cycles mid-burst with grantee valid -> no transfer, beat_cnt_o frozen, no timeout.
- TOW=3, grantee drops rval after beat 2 with no lack -> release after 7 idle cycles, timeout_o pulses once, and the other source is granted.
- err=1 on beat 2 of an 8-beat burst -> release after beat 2, beat_cnt_o=2.
